// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter: counts ship/asteroid and torpedo/asteroid pixel
// overlaps over a frame and converts them into single event pulses at frame_start.
module collision_arbiter #(
    parameter int T_NUM        = 4,
    parameter int A_NUM        = 8,
    parameter int MIN_OVERLAP  = 2,
    parameter int GRACE_FRAMES = 120
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             frame_start,
    input  logic             game_over,
    input  logic             draw_ship,
    input  logic [A_NUM-1:0] draw_asteroid,
    input  logic [T_NUM-1:0] draw_torpedo,
    output logic             die,
    output logic             ship_invuln,
    output logic [T_NUM-1:0] torpedo_kill,
    output logic [A_NUM-1:0] asteroid_hit,
    output logic             score_add,
    output logic [3:0]       score_sum
);

    localparam int CW = $clog2(MIN_OVERLAP + 1);
    localparam logic [CW-1:0] SAT      = CW'(MIN_OVERLAP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    GRACE_LD = 8'(GRACE_FRAMES);

    logic [CW-1:0] ship_cnt [A_NUM];
    logic [CW-1:0] tor_cnt  [T_NUM][A_NUM];
    logic [7:0]    grace;

    logic             ship_hit;
    logic             die_cond;
    logic [T_NUM-1:0] tk;
    logic [A_NUM-1:0] ah;
    logic [A_NUM-1:0] ah_m;
    logic [3:0]       ah_pop;

    // Evaluation only ever looks at the registered counts, so draws on the
    // frame_start cycle itself never contribute.
    always_comb begin
        ship_hit = 1'b0;
        tk       = '0;
        ah       = '0;
        for (int a = 0; a < A_NUM; a++) begin
            if (ship_cnt[a] == SAT) ship_hit = 1'b1;
            for (int t = 0; t < T_NUM; t++) begin
                if (tor_cnt[t][a] == SAT) begin
                    tk[t] = 1'b1;
                    ah[a] = 1'b1;
                end
            end
        end
        die_cond = ship_hit && (grace == 8'd0) && !game_over;
        ah_m     = game_over ? '0 : ah;
        ah_pop   = '0;
        for (int a = 0; a < A_NUM; a++) begin
            ah_pop = ah_pop + 4'(ah_m[a]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int a = 0; a < A_NUM; a++) begin
                ship_cnt[a] <= '0;
                for (int t = 0; t < T_NUM; t++) tor_cnt[t][a] <= '0;
            end
            grace        <= 8'd0;
            die          <= 1'b0;
            ship_invuln  <= 1'b0;
            torpedo_kill <= '0;
            asteroid_hit <= '0;
            score_add    <= 1'b0;
            score_sum    <= 4'd0;
        end else begin
            ship_invuln <= (grace != 8'd0);
            if (frame_start) begin
                for (int a = 0; a < A_NUM; a++) begin
                    ship_cnt[a] <= '0;
                    for (int t = 0; t < T_NUM; t++) tor_cnt[t][a] <= '0;
                end
                die          <= die_cond;
                torpedo_kill <= game_over ? '0 : tk;
                asteroid_hit <= ah_m;
                score_sum    <= ah_pop;
                score_add    <= (ah_pop != 4'd0);
                // game_over masks die_cond, so the countdown keeps running.
                if (die_cond)
                    grace <= GRACE_LD;
                else if (grace != 8'd0)
                    grace <= grace - 8'd1;
            end else begin
                die          <= 1'b0;
                torpedo_kill <= '0;
                asteroid_hit <= '0;
                score_add    <= 1'b0;
                for (int a = 0; a < A_NUM; a++) begin
                    if (draw_ship && draw_asteroid[a] && ship_cnt[a] != SAT)
                        ship_cnt[a] <= ship_cnt[a] + CNT_ONE;
                    for (int t = 0; t < T_NUM; t++) begin
                        if (draw_torpedo[t] && draw_asteroid[a] && tor_cnt[t][a] != SAT)
                            tor_cnt[t][a] <= tor_cnt[t][a] + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter with a short grace window (3 frames).
module tb_collision_arbiter;

    localparam int T_NUM = 4;
    localparam int A_NUM = 8;

    logic             clk;
    logic             resetN;
    logic             frame_start;
    logic             game_over;
    logic             draw_ship;
    logic [A_NUM-1:0] draw_asteroid;
    logic [T_NUM-1:0] draw_torpedo;
    logic             die;
    logic             ship_invuln;
    logic [T_NUM-1:0] torpedo_kill;
    logic [A_NUM-1:0] asteroid_hit;
    logic             score_add;
    logic [3:0]       score_sum;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    collision_arbiter #(
        .T_NUM(T_NUM), .A_NUM(A_NUM), .MIN_OVERLAP(2), .GRACE_FRAMES(3)
    ) dut (
        .clk(clk), .resetN(resetN), .frame_start(frame_start), .game_over(game_over),
        .draw_ship(draw_ship), .draw_asteroid(draw_asteroid), .draw_torpedo(draw_torpedo),
        .die(die), .ship_invuln(ship_invuln), .torpedo_kill(torpedo_kill),
        .asteroid_hit(asteroid_hit), .score_add(score_add), .score_sum(score_sum)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        draw_ship     = 1'b0;
        draw_asteroid = '0;
        draw_torpedo  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        frame_start = 1'b0;
        game_over   = 1'b0;
        resetN      = 1'b0;
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic overlap(input int n, input logic ship, input logic [A_NUM-1:0] ast,
                           input logic [T_NUM-1:0] tor);
        draw_ship     = ship;
        draw_asteroid = ast;
        draw_torpedo  = tor;
        repeat (n) step();
        idle_inputs();
    endtask

    // After return, outputs show the evaluation of the frame just ended.
    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic chk_events(input string tag, input logic d, input logic [T_NUM-1:0] tkx,
                              input logic [A_NUM-1:0] ahx, input logic [3:0] sum);
        chk({tag, ".die"}, 32'(die), 32'(d));
        chk({tag, ".torpedo_kill"}, 32'(torpedo_kill), 32'(tkx));
        chk({tag, ".asteroid_hit"}, 32'(asteroid_hit), 32'(ahx));
        chk({tag, ".score_sum"}, 32'(score_sum), 32'(sum));
        chk({tag, ".score_add"}, 32'(score_add), 32'(sum != 4'd0));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".die"}, 32'(die), 32'd0);
        chk({tag, ".torpedo_kill"}, 32'(torpedo_kill), 32'd0);
        chk({tag, ".asteroid_hit"}, 32'(asteroid_hit), 32'd0);
        chk({tag, ".score_add"}, 32'(score_add), 32'd0);
    endtask

    int die_seen;
    logic [7:0] exp_die;
    logic [7:0] inv_tab [6];

    initial begin
        idle_inputs();
        frame_start = 1'b0;
        game_over   = 1'b0;
        resetN      = 1'b0;
        #1;
        chk("por.invuln", 32'(ship_invuln), 32'd0);
        chk_events("por", 1'b0, 4'h0, 8'h00, 4'd0);
        step();
        resetN = 1'b1;
        step();

        // Reset mid-frame with full accumulators.
        overlap(2, 1'b1, 8'b0000_1000, 4'b0001);
        draw_ship = 1'b1; draw_asteroid = 8'b0000_1000; draw_torpedo = 4'b0001;
        #2;
        resetN = 1'b0;
        #1;
        chk_events("rst_mid", 1'b0, 4'h0, 8'h00, 4'd0);
        chk("rst_mid.invuln", 32'(ship_invuln), 32'd0);
        idle_inputs();
        step();
        resetN = 1'b1;
        step();
        frame();
        chk_events("rst_next", 1'b0, 4'h0, 8'h00, 4'd0);

        // Threshold: one overlap pixel is below MIN_OVERLAP.
        do_reset();
        overlap(1, 1'b1, 8'b0000_1000, 4'b0000);
        frame();
        chk("thr1.die", 32'(die), 32'd0);

        do_reset();
        overlap(2, 1'b1, 8'b0000_1000, 4'b0000);
        chk("thr2.pre", 32'(die), 32'd0);
        frame();
        chk("thr2.die", 32'(die), 32'd1);
        step();
        chk("thr2.drop", 32'(die), 32'd0);

        // Saturation: long overlap still yields a single pulse.
        do_reset();
        die_seen = 0;
        draw_ship = 1'b1; draw_asteroid = 8'b0000_1000;
        repeat (500) begin
            step();
            if (die) die_seen++;
        end
        idle_inputs();
        frame();
        if (die) die_seen++;
        repeat (3) begin
            step();
            if (die) die_seen++;
        end
        chk("sat.count", 32'(die_seen), 32'd1);

        // Grace window of 3 frames: die at frames 0 and 4 only.
        do_reset();
        exp_q = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
        inv_tab = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1};
        for (int f = 0; f < 6; f++) begin
            overlap(2, 1'b1, 8'b0000_1000, 4'b0000);
            frame();
            exp_die = exp_q.pop_front();
            chk($sformatf("grace.f%0d.die", f), 32'(die), 32'(exp_die));
            if (f == 0) chk("grace.f0.invuln_at_die", 32'(ship_invuln), 32'd0);
            step();
            chk($sformatf("grace.f%0d.invuln", f), 32'(ship_invuln), 32'(inv_tab[f]));
        end
        chk("grace.queue_empty", 32'(exp_q.size()), 32'd0);

        // Multi-hit: t0 -> a1, a2; t2 -> a2.
        do_reset();
        overlap(2, 1'b0, 8'b0000_0010, 4'b0001);
        overlap(2, 1'b0, 8'b0000_0100, 4'b0101);
        frame();
        chk_events("multi", 1'b0, 4'b0101, 8'b0000_0110, 4'd2);
        step();
        chk_quiet("multi.next");
        chk("multi.sum_hold", 32'(score_sum), 32'd2);

        // Ship and torpedo 1 hit asteroid 5 in the same frame.
        do_reset();
        overlap(2, 1'b1, 8'b0010_0000, 4'b0010);
        frame();
        chk_events("simul", 1'b1, 4'b0010, 8'b0010_0000, 4'd1);

        // game_over masks pulses but the grace countdown continues.
        do_reset();
        overlap(2, 1'b1, 8'b0000_0001, 4'b0000);
        frame();
        chk("go.load_die", 32'(die), 32'd1);
        game_over = 1'b1;
        overlap(2, 1'b1, 8'b1000_0001, 4'b1000);
        frame();
        chk_events("go.masked", 1'b0, 4'h0, 8'h00, 4'd0);
        step();
        chk("go.invuln_g2", 32'(ship_invuln), 32'd1);
        frame();
        step();
        chk("go.invuln_g1", 32'(ship_invuln), 32'd1);
        frame();
        step();
        chk("go.invuln_g0", 32'(ship_invuln), 32'd0);
        overlap(2, 1'b1, 8'b0000_0001, 4'b0000);
        frame();
        chk("go.die_masked", 32'(die), 32'd0);
        step();
        chk("go.no_reload", 32'(ship_invuln), 32'd0);
        game_over = 1'b0;

        // Overlap present only on the frame_start cycle is ignored.
        do_reset();
        draw_ship = 1'b1; draw_asteroid = 8'b0000_0100; draw_torpedo = 4'b0100;
        frame();
        idle_inputs();
        chk_quiet("fs_only.same");
        step();
        frame();
        chk_quiet("fs_only.next");

        // Back-to-back frame_start: second evaluates cleared counters.
        do_reset();
        overlap(2, 1'b0, 8'b0001_0000, 4'b1000);
        frame_start = 1'b1;
        step();
        chk_events("b2b.first", 1'b0, 4'b1000, 8'b0001_0000, 4'd1);
        step();
        frame_start = 1'b0;
        chk_quiet("b2b.second");
        chk("b2b.sum", 32'(score_sum), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
